// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder that streams machine words into instruction memory from address 0.
// Optional macro ENC_RANGE_CHECK_EN drops bundles whose immediates do not fit their format.
module instr_encoder_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        fmt,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic              funct7b5,
   input  logic [20:0]       imm,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
   state_t state;

   function automatic logic [31:0] encode(input logic [2:0] f, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [2:0] f3, input logic b5,
                                          input logic [20:0] im);
      logic [11:0] imm_i;
      logic [31:0] w;
      // Shift-immediates carry the arithmetic/logical selector in bit 30 instead of imm[11:5].
      imm_i = (f3 == 3'b001 || f3 == 3'b101) ? {1'b0, b5, 5'b00000, im[4:0]} : im[11:0];
      case (f)
         3'd0:    w = {im[11:0], s1, 3'b010, d, 7'h03};
         3'd1:    w = {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
         3'd2:    w = {1'b0, b5, 5'b00000, s2, s1, f3, d, 7'h33};
         3'd3:    w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
         3'd4:    w = {imm_i, s1, f3, d, 7'h13};
         3'd5:    w = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   function automatic logic bundle_ok(input logic [2:0] f, input logic signed [20:0] im);
      logic ok;
      ok = (f <= 3'd5);
`ifdef ENC_RANGE_CHECK_EN
      case (f)
         3'd0, 3'd1, 3'd4: ok = (im >= -21'sd2048) && (im <= 21'sd2047);
         3'd3:             ok = (im >= -21'sd4096) && (im <= 21'sd4094) && !im[0];
         3'd5:             ok = !im[0];
         default:          ok = ok;
      endcase
`endif
      return ok;
   endfunction

   logic        legal;
   logic [31:0] enc;
   logic signed [20:0] simm;

   always_comb begin
      simm  = imm;
      legal = bundle_ok(fmt, simm);
      enc   = encode(fmt, rd, rs1, rs2, funct3, funct7b5, imm);
   end

   assign in_ready = (state == LOAD);
   assign done     = (state == FIN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         count   <= '0;
         err     <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  state <= LOAD;
                  count <= '0;
                  err   <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  if (legal) begin
                     wr_en   <= 1'b1;
                     wr_data <= enc;
                     wr_addr <= count[ADDR_W-1:0];
                     count   <= count + (ADDR_W+1)'(1);
                  end else begin
                     err <= 1'b1;
                  end
                  // A legal write into the top address fills the memory.
                  if (in_last || (legal && (&count[ADDR_W-1:0])))
                     state <= FIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: vector table plus reset, abort and memory-full sequences.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst, start, start2, in_valid, in_last, funct7b5;
   logic [2:0]  fmt, funct3;
   logic [4:0]  rd, rs1, rs2;
   logic [20:0] imm;

   logic        in_ready, wr_en, done, err;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;
   logic [6:0]  count;

   logic        in_ready2, wr_en2, done2, err2;
   logic [1:0]  wr_addr2;
   logic [31:0] wr_data2;
   logic [2:0]  count2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7b5(funct7b5), .imm(imm), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .count(count), .done(done), .err(err));

   instr_encoder_loader #(.ADDR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
      .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
      .funct7b5(funct7b5), .imm(imm), .wr_en(wr_en2), .wr_addr(wr_addr2),
      .wr_data(wr_data2), .count(count2), .done(done2), .err(err2));

   typedef struct {
      logic [2:0]  fmt;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  funct3;
      logic        b5;
      logic [20:0] imm;
      logic        last;
      logic        exp_wr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      fmt = v.fmt; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
      funct3 = v.funct3; funct7b5 = v.b5; imm = v.imm; in_last = v.last;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_last = 1'b0; fmt = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      funct3 = 3'd0; funct7b5 = 1'b0; imm = 21'd0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      int exp_addr;
      vec_t v;
      //            fmt   rd     rs1    rs2    f3      b5    imm        last  wr    data
      tbl[0] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 21'd0,     1'b0, 1'b1, 32'h002081B3};
      tbl[1] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 21'd0,     1'b0, 1'b1, 32'h402081B3};
      tbl[2] = '{3'd0, 5'd5, 5'd2, 5'd0, 3'd7, 1'b0, 21'd8,     1'b0, 1'b1, 32'h00812283};
      tbl[3] = '{3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 21'd12,    1'b0, 1'b1, 32'h00512623};
      tbl[4] = '{3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0,     1'b0, 1'b0, 32'h00512623};
      tbl[5] = '{3'd4, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 21'h23,    1'b0, 1'b1, 32'h40315093};
      tbl[6] = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1FFFFC,1'b0, 1'b1, 32'hFE208EE3};
      tbl[7] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd8,     1'b1, 1'b1, 32'h008000EF};

      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset wr_en",    32'(wr_en),    32'd0);
      chk("reset wr_addr",  32'(wr_addr),  32'd0);
      chk("reset wr_data",  wr_data,       32'd0);
      chk("reset count",    32'(count),    32'd0);
      chk("reset done",     32'(done),     32'd0);
      chk("reset err",      32'(err),      32'd0);
      rst = 1'b0;

      pulse_start();
      chk("in_ready after start", 32'(in_ready), 32'd1);

      exp_addr = 0;
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wr));
         chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].exp_data);
         if (tbl[i].exp_wr) begin
            chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(exp_addr));
            exp_addr++;
         end
         chk($sformatf("vec%0d count", i), 32'(count), 32'(exp_addr));
         if (i == 4) chk("err after illegal fmt", 32'(err), 32'd1);
      end
      idle_inputs();
      chk("done with last write", 32'(done), 32'd1);
      @(negedge clk);
      chk("in_ready after last", 32'(in_ready), 32'd0);
      chk("wr_en after last",    32'(wr_en),    32'd0);
      chk("wr_data held",        wr_data,       32'h008000EF);
      chk("final count",         32'(count),    32'd7);
      chk("err sticky",          32'(err),      32'd1);
      chk("done holds",          32'(done),     32'd1);

      pulse_start();
      chk("err cleared on start",   32'(err),   32'd0);
      chk("count cleared on start", 32'(count), 32'd0);
      chk("done cleared on start",  32'(done),  32'd0);
      v = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048, 1'b1, 1'b0, 32'h0};
      drive(v);
      @(negedge clk);
      idle_inputs();
`ifdef ENC_RANGE_CHECK_EN
      chk("range imm2048 wr_en", 32'(wr_en), 32'd0);
      chk("range imm2048 err",   32'(err),   32'd1);
      chk("range imm2048 count", 32'(count), 32'd0);
`else
      chk("trunc imm2048 wr_en", 32'(wr_en), 32'd1);
      chk("trunc imm2048 data",  wr_data,    32'h80000093);
      chk("trunc imm2048 err",   32'(err),   32'd0);
`endif
      chk("imm2048 done", 32'(done), 32'd1);

      // Reset in the same cycle as an accept discards the write.
      pulse_start();
      drive(tbl[0]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      chk("abort wr_en",    32'(wr_en),    32'd0);
      chk("abort in_ready", 32'(in_ready), 32'd0);
      chk("abort count",    32'(count),    32'd0);

      // Reset beats a simultaneous start.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst over start in_ready", 32'(in_ready), 32'd0);
      chk("rst over start done",     32'(done),     32'd0);

      // Four-word memory fills after four accepts; the fifth bundle is not taken.
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = '{3'd2, 5'(i + 1), 5'd1, 5'd2, 3'd0, 1'b0, 21'd0, 1'b0, 1'b0, 32'h0};
         drive(v);
         @(negedge clk);
         chk($sformatf("full%0d wr_en", i), 32'(wr_en2), (i < 4) ? 32'd1 : 32'd0);
         if (i < 4) begin
            chk($sformatf("full%0d wr_addr", i), 32'(wr_addr2), 32'(i));
            chk($sformatf("full%0d wr_data", i), wr_data2,
                32'h00208033 | (32'(i + 1) << 7));
         end
         if (i == 3) chk("full done with 4th write", 32'(done2), 32'd1);
      end
      idle_inputs();
      chk("full in_ready", 32'(in_ready2), 32'd0);
      chk("full count",    32'(count2),    32'd4);
      chk("full done",     32'(done2),     32'd1);
      chk("full err",      32'(err2),      32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
